// File: rtl/mem_req_arbiter.sv
// Posted-write FIFO: single-clock, count-based full/empty, pointers wrap naturally.
// Latency: pushed entry visible at head_dat the cycle after the push edge.
// Backpressure: push ignored while full, pop ignored while empty; push+pop together keep count.
module mem_req_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_rdy,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          push;
    logic          pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign push     = push_vld && !full;
    assign pop      = pop_rdy && !empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end
endmodule

// VIC/CPU request front-end serialising byte transactions onto the PSRAM controller handshake.
// Latency: grant 1 cycle after a candidate appears in IDLE, o_cs low the following cycle.
// Backpressure: o_vicReady/o_cpuReady drop while the pending-read slot or the write FIFO is occupied.
module mem_req_arbiter #(
    parameter int ADDR_W     = 24,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              i_clkRAM,
    input  logic              reset,
    input  logic              i_vicReq,
    input  logic [ADDR_W-1:0] i_vicAddress,
    output logic              o_vicReady,
    output logic [7:0]        o_vicData,
    output logic              o_vicValid,
    input  logic              i_cpuReq,
    input  logic              i_cpuWrite,
    input  logic              i_cpuBank,
    input  logic [ADDR_W-1:0] i_cpuAddress,
    input  logic [7:0]        i_cpuData,
    output logic              o_cpuReady,
    output logic [7:0]        o_cpuData,
    output logic              o_cpuValid,
    output logic              o_cs,
    output logic              o_write,
    output logic              o_bank,
    output logic [ADDR_W-1:0] o_address,
    output logic [7:0]        o_dataToWrite,
    input  logic              i_busy,
    input  logic [7:0]        i_dataRead,
    input  logic              i_dataReady,
    output logic              o_error
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
    typedef enum logic {SIDE_CPU, SIDE_VIC} side_t;
    typedef struct packed {
        logic              bank;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        dat;
    } wr_req_t;

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    side_t             last_grant_q, owner_q, grant_side;
    logic              grant, txn_done, txn_abort, txn_end;
    logic              vic_pend_q;
    logic [ADDR_W-1:0] vic_addr_q;
    logic              cpu_rd_pend_q, cpu_rd_bank_q;
    logic [ADDR_W-1:0] cpu_rd_addr_q;
    logic [CNT_W-1:0]  wd_cnt_q;
    logic              wd_expired;
    logic              vic_acc, cpu_rd_acc, cpu_cand;
    wr_req_t           fifo_in_dat, fifo_head_dat;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;

    assign o_vicReady  = !vic_pend_q;
    assign o_cpuReady  = i_cpuWrite ? !fifo_full : !cpu_rd_pend_q;
    assign vic_acc     = i_vicReq && !vic_pend_q;
    assign fifo_push   = i_cpuReq && i_cpuWrite && !fifo_full;
    assign cpu_rd_acc  = i_cpuReq && !i_cpuWrite && !cpu_rd_pend_q;
    assign fifo_in_dat = '{bank: i_cpuBank, addr: i_cpuAddress, dat: i_cpuData};
    // A pending CPU read only competes once the posted writes have drained.
    assign cpu_cand    = !fifo_empty || cpu_rd_pend_q;
    assign wd_expired  = (wd_cnt_q == WD_LAST);
    assign txn_end     = txn_done || txn_abort;
    assign fifo_pop    = txn_end && o_write;
    assign o_cs        = (state_q != ISSUE);

    mem_req_fifo #(
        .W     ($bits(wr_req_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk      (i_clkRAM),
        .reset    (reset),
        .push_vld (fifo_push),
        .push_dat (fifo_in_dat),
        .pop_rdy  (fifo_pop),
        .head_dat (fifo_head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        grant      = 1'b0;
        grant_side = SIDE_CPU;
        txn_done   = 1'b0;
        txn_abort  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!i_busy && (vic_pend_q || cpu_cand)) begin
                    grant = 1'b1;
                    if (vic_pend_q && cpu_cand)
                        grant_side = (last_grant_q == SIDE_VIC) ? SIDE_CPU : SIDE_VIC;
                    else
                        grant_side = vic_pend_q ? SIDE_VIC : SIDE_CPU;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (i_busy) begin
                    state_d = WAIT_DONE;
                end else if (wd_expired) begin
                    txn_abort = 1'b1;
                    state_d   = IDLE;
                end
            end
            WAIT_DONE: begin
                if (o_write ? !i_busy : i_dataReady) begin
                    txn_done = 1'b1;
                    state_d  = IDLE;
                end else if (wd_expired) begin
                    txn_abort = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clkRAM) begin
        if (reset) begin
            state_q       <= IDLE;
            last_grant_q  <= SIDE_CPU;
            owner_q       <= SIDE_CPU;
            vic_pend_q    <= 1'b0;
            vic_addr_q    <= '0;
            cpu_rd_pend_q <= 1'b0;
            cpu_rd_bank_q <= 1'b0;
            cpu_rd_addr_q <= '0;
            wd_cnt_q      <= '0;
            o_write       <= 1'b0;
            o_bank        <= 1'b0;
            o_address     <= '0;
            o_dataToWrite <= '0;
            o_vicData     <= '0;
            o_cpuData     <= '0;
            o_vicValid    <= 1'b0;
            o_cpuValid    <= 1'b0;
            o_error       <= 1'b0;
        end else begin
            state_q    <= state_d;
            o_vicValid <= 1'b0;
            o_cpuValid <= 1'b0;

            // Restart the watchdog on every state change so each wait phase gets a full budget.
            if (state_d != state_q)
                wd_cnt_q <= '0;
            else if (state_q == WAIT_BUSY || state_q == WAIT_DONE)
                wd_cnt_q <= wd_cnt_q + 1'b1;

            if (vic_acc) begin
                vic_pend_q <= 1'b1;
                vic_addr_q <= i_vicAddress;
            end
            if (cpu_rd_acc) begin
                cpu_rd_pend_q <= 1'b1;
                cpu_rd_bank_q <= i_cpuBank;
                cpu_rd_addr_q <= i_cpuAddress;
            end

            if (grant) begin
                last_grant_q <= grant_side;
                owner_q      <= grant_side;
                if (grant_side == SIDE_VIC) begin
                    o_write       <= 1'b0;
                    o_bank        <= 1'b0;
                    o_address     <= vic_addr_q;
                    o_dataToWrite <= '0;
                end else if (!fifo_empty) begin
                    o_write       <= 1'b1;
                    o_bank        <= fifo_head_dat.bank;
                    o_address     <= fifo_head_dat.addr;
                    o_dataToWrite <= fifo_head_dat.dat;
                end else begin
                    o_write       <= 1'b0;
                    o_bank        <= cpu_rd_bank_q;
                    o_address     <= cpu_rd_addr_q;
                    o_dataToWrite <= '0;
                end
            end

            // Reads free their slot on completion or abort; only completion returns data.
            if (txn_end && !o_write) begin
                if (owner_q == SIDE_VIC) begin
                    vic_pend_q <= 1'b0;
                    if (txn_done) begin
                        o_vicData  <= i_dataRead;
                        o_vicValid <= 1'b1;
                    end
                end else begin
                    cpu_rd_pend_q <= 1'b0;
                    if (txn_done) begin
                        o_cpuData  <= i_dataRead;
                        o_cpuValid <= 1'b1;
                    end
                end
            end

            if (txn_abort) o_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter; the bench plays the PSRAM controller handshake.
module tb_mem_req_arbiter;
    logic        i_clkRAM = 1'b0;
    logic        reset;
    logic        i_vicReq;
    logic [23:0] i_vicAddress;
    logic        o_vicReady;
    logic [7:0]  o_vicData;
    logic        o_vicValid;
    logic        i_cpuReq;
    logic        i_cpuWrite;
    logic        i_cpuBank;
    logic [23:0] i_cpuAddress;
    logic [7:0]  i_cpuData;
    logic        o_cpuReady;
    logic [7:0]  o_cpuData;
    logic        o_cpuValid;
    logic        o_cs;
    logic        o_write;
    logic        o_bank;
    logic [23:0] o_address;
    logic [7:0]  o_dataToWrite;
    logic        i_busy;
    logic [7:0]  i_dataRead;
    logic        i_dataReady;
    logic        o_error;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] model_mem [logic [23:0]];

    always #5 i_clkRAM = ~i_clkRAM;

    mem_req_arbiter dut (
        .i_clkRAM      (i_clkRAM),
        .reset         (reset),
        .i_vicReq      (i_vicReq),
        .i_vicAddress  (i_vicAddress),
        .o_vicReady    (o_vicReady),
        .o_vicData     (o_vicData),
        .o_vicValid    (o_vicValid),
        .i_cpuReq      (i_cpuReq),
        .i_cpuWrite    (i_cpuWrite),
        .i_cpuBank     (i_cpuBank),
        .i_cpuAddress  (i_cpuAddress),
        .i_cpuData     (i_cpuData),
        .o_cpuReady    (o_cpuReady),
        .o_cpuData     (o_cpuData),
        .o_cpuValid    (o_cpuValid),
        .o_cs          (o_cs),
        .o_write       (o_write),
        .o_bank        (o_bank),
        .o_address     (o_address),
        .o_dataToWrite (o_dataToWrite),
        .i_busy        (i_busy),
        .i_dataRead    (i_dataRead),
        .i_dataReady   (i_dataReady),
        .o_error       (o_error)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clkRAM);
        #1;
    endtask

    task automatic wait_cs(input string tag);
        int n = 0;
        while (o_cs !== 1'b0 && n < 60) begin
            step();
            n++;
        end
        chk({tag, "_cs"}, 32'(o_cs), 32'd0);
    endtask

    // Waits for a select pulse, checks the latched request, then completes it.
    // Leaves i_busy=1 so the next grant happens only when the caller releases it.
    task automatic serve(input string tag, input logic wr, input logic bank,
                         input logic [23:0] addr, input logic [7:0] wdat,
                         input logic [7:0] rdat, input logic vic_side);
        wait_cs(tag);
        chk({tag, "_write"}, 32'(o_write), 32'(wr));
        chk({tag, "_bank"}, 32'(o_bank), 32'(bank));
        chk({tag, "_addr"}, 32'(o_address), 32'(addr));
        if (wr) begin
            chk({tag, "_wdata"}, 32'(o_dataToWrite), 32'(wdat));
            model_mem[addr] = wdat;
        end
        i_busy = 1'b1;
        step();
        step();
        chk({tag, "_hold"}, 32'(o_address), 32'(addr));
        if (wr) begin
            i_busy = 1'b0;
            step();
            i_busy = 1'b1;
            chk({tag, "_novalid"}, 32'({o_vicValid, o_cpuValid}), 32'd0);
        end else begin
            i_dataReady = 1'b1;
            i_dataRead  = rdat;
            step();
            i_dataReady = 1'b0;
            chk({tag, "_vicvld"}, 32'(o_vicValid), 32'(vic_side));
            chk({tag, "_cpuvld"}, 32'(o_cpuValid), 32'(!vic_side));
            chk({tag, "_rdata"}, 32'(vic_side ? o_vicData : o_cpuData), 32'(rdat));
            step();
            chk({tag, "_pulse"}, 32'({o_vicValid, o_cpuValid}), 32'd0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: still running at %0t, required to finish earlier", $time);
        $fatal(1, "bench did not terminate");
    end

    initial begin
        logic [23:0] vic_a;
        logic [23:0] cpu_a;
        int n;

        reset = 1'b1; i_busy = 1'b1;
        i_vicReq = 1'b0; i_vicAddress = '0;
        i_cpuReq = 1'b0; i_cpuWrite = 1'b0; i_cpuBank = 1'b0; i_cpuAddress = '0; i_cpuData = '0;
        i_dataRead = '0; i_dataReady = 1'b0;
        repeat (3) step();
        chk("rst_cs", 32'(o_cs), 32'd1);
        chk("rst_vic_ready", 32'(o_vicReady), 32'd1);
        chk("rst_cpu_ready", 32'(o_cpuReady), 32'd1);
        chk("rst_error", 32'(o_error), 32'd0);
        chk("rst_valids", 32'({o_vicValid, o_cpuValid}), 32'd0);
        chk("rst_addr", 32'(o_address), 32'd0);
        chk("rst_write", 32'(o_write), 32'd0);

        // VIC read held off while the controller initialises.
        reset = 1'b0;
        i_vicReq = 1'b1; i_vicAddress = 24'h00AAAA;
        step();
        i_vicReq = 1'b0;
        chk("t1_vic_busy", 32'(o_vicReady), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t1_cs_held", 32'(o_cs), 32'd1);
        end
        i_busy = 1'b0;
        serve("t1", 1'b0, 1'b0, 24'h00AAAA, 8'h00, 8'hF0, 1'b1);
        chk("t1_vic_free", 32'(o_vicReady), 32'd1);

        // Fill the posted-write FIFO, then drain it in order.
        i_cpuWrite = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_cpuReq = 1'b1;
            i_cpuAddress = 24'(24'h10 + i);
            i_cpuData = 8'(8'h11 * (i + 1));
            i_cpuBank = i[0];
            #1;
            chk("t2_ready_pre", 32'(o_cpuReady), 32'd1);
            step();
        end
        i_cpuReq = 1'b0;
        chk("t2_full", 32'(o_cpuReady), 32'd0);
        for (int i = 0; i < 4; i++) begin
            i_busy = 1'b0;
            serve($sformatf("t2_w%0d", i), 1'b1, i[0], 24'(24'h10 + i), 8'(8'h11 * (i + 1)), 8'h00, 1'b0);
            if (i == 0) chk("t2_ready_after_pop", 32'(o_cpuReady), 32'd1);
        end

        // Read-after-write to the same address.
        i_cpuReq = 1'b1; i_cpuWrite = 1'b1; i_cpuBank = 1'b0;
        i_cpuAddress = 24'h000020; i_cpuData = 8'h5A;
        step();
        i_cpuWrite = 1'b0;
        #1;
        chk("t3_rd_ready", 32'(o_cpuReady), 32'd1);
        step();
        i_cpuReq = 1'b0;
        #1;
        chk("t3_rd_slot_taken", 32'(o_cpuReady), 32'd0);
        i_busy = 1'b0;
        serve("t3_w", 1'b1, 1'b0, 24'h000020, 8'h5A, 8'h00, 1'b0);
        i_busy = 1'b0;
        serve("t3_r", 1'b0, 1'b0, 24'h000020, 8'h00, model_mem[24'h000020], 1'b0);
        chk("t3_rd_slot_free", 32'(o_cpuReady), 32'd1);

        // Both sides kept pending: last grant was CPU, so VIC, CPU, VIC, ...
        vic_a = 24'h000100;
        cpu_a = 24'h000200;
        i_vicReq = 1'b1; i_vicAddress = vic_a;
        i_cpuReq = 1'b1; i_cpuWrite = 1'b0; i_cpuAddress = cpu_a;
        step();
        i_vicReq = 1'b0; i_cpuReq = 1'b0;
        for (int k = 0; k < 10; k++) begin
            i_busy = 1'b0;
            if (k % 2 == 0) begin
                serve($sformatf("t4_v%0d", k), 1'b0, 1'b0, vic_a, 8'h00, vic_a[7:0] ^ 8'hA5, 1'b1);
                vic_a = vic_a + 24'd1;
                i_vicReq = (k < 8);
                i_vicAddress = vic_a;
            end else begin
                serve($sformatf("t4_c%0d", k), 1'b0, 1'b0, cpu_a, 8'h00, cpu_a[7:0] ^ 8'h3C, 1'b0);
                cpu_a = cpu_a + 24'd1;
                i_cpuReq = (k < 8);
                i_cpuAddress = cpu_a;
            end
            step();
            i_vicReq = 1'b0; i_cpuReq = 1'b0;
        end

        // Controller never answers: watchdog aborts, later requests still served.
        i_busy = 1'b0;
        i_vicReq = 1'b1; i_vicAddress = 24'h000300;
        step();
        i_vicReq = 1'b0;
        wait_cs("t5");
        chk("t5_addr", 32'(o_address), 32'h300);
        repeat (250) step();
        chk("t5_no_err_yet", 32'(o_error), 32'd0);
        n = 0;
        while (o_error !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("t5_error", 32'(o_error), 32'd1);
        chk("t5_no_valid", 32'({o_vicValid, o_cpuValid}), 32'd0);
        chk("t5_slot_free", 32'(o_vicReady), 32'd1);
        i_vicReq = 1'b1; i_vicAddress = 24'h000301;
        step();
        i_vicReq = 1'b0;
        serve("t5b", 1'b0, 1'b0, 24'h000301, 8'h00, 8'h3C, 1'b1);
        chk("t5_error_sticky", 32'(o_error), 32'd1);

        // Reset while a VIC read sits in WAIT_DONE with writes still queued.
        i_cpuWrite = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_cpuReq = 1'b1;
            i_cpuAddress = 24'(24'h30 + i);
            i_cpuData = 8'(8'h60 + i);
            i_cpuBank = 1'b0;
            step();
        end
        i_cpuReq = 1'b0;
        chk("t6_full", 32'(o_cpuReady), 32'd0);
        i_vicReq = 1'b1; i_vicAddress = 24'h000400;
        step();
        i_vicReq = 1'b0;
        i_busy = 1'b0;
        serve("t6_w", 1'b1, 1'b0, 24'h000030, 8'h60, 8'h00, 1'b0);
        i_busy = 1'b0;
        wait_cs("t6_v");
        chk("t6_v_addr", 32'(o_address), 32'h400);
        i_busy = 1'b1;
        step();
        step();
        reset = 1'b1;
        i_dataReady = 1'b1; i_dataRead = 8'h77;
        step();
        i_dataReady = 1'b0;
        chk("t6_no_valid", 32'({o_vicValid, o_cpuValid}), 32'd0);
        chk("t6_cs", 32'(o_cs), 32'd1);
        chk("t6_vic_ready", 32'(o_vicReady), 32'd1);
        step();
        chk("t6_no_valid_late", 32'({o_vicValid, o_cpuValid}), 32'd0);
        reset = 1'b0;
        chk("t6_error_cleared", 32'(o_error), 32'd0);
        for (int i = 0; i < 3; i++) begin
            i_cpuReq = 1'b1;
            i_cpuAddress = 24'(24'h40 + i);
            i_cpuData = 8'(i);
            step();
        end
        i_cpuReq = 1'b0;
        chk("t6_fifo_was_empty", 32'(o_cpuReady), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
